// File: rtl/jac1_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// jac1_mem_arbiter_if
// Bus bundle between the three RAM requesters (fetch, data, debug loader),
// the arbiter and the single-port RAM.
//   i_*  : fetch port    (req/addr in, rdata/ack out)
//   d_*  : data port     (req/we/addr/wdata in, rdata/ack out)
//   g_*  : debug port    (same shape as data port)
//   mem_*: RAM side      (en/we/addr/wdata out, rdata in, synchronous read)
//   busy : arbiter is not idle
// Modports:
//   slave  - the arbiter's view
//   master - the requesters' and RAM's view
// ---------------------------------------------------------------------------
interface jac1_mem_arbiter_if #(
   parameter int DataWidth = 8,
   parameter int AddrWidth = 8
);
   logic                 i_req;
   logic [AddrWidth-1:0] i_addr;
   logic [DataWidth-1:0] i_rdata;
   logic                 i_ack;

   logic                 d_req;
   logic                 d_we;
   logic [AddrWidth-1:0] d_addr;
   logic [DataWidth-1:0] d_wdata;
   logic [DataWidth-1:0] d_rdata;
   logic                 d_ack;

   logic                 g_req;
   logic                 g_we;
   logic [AddrWidth-1:0] g_addr;
   logic [DataWidth-1:0] g_wdata;
   logic [DataWidth-1:0] g_rdata;
   logic                 g_ack;

   logic                 mem_en;
   logic                 mem_we;
   logic [AddrWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_wdata;
   logic [DataWidth-1:0] mem_rdata;

   logic                 busy;

   modport slave (
      input  i_req, i_addr,
      output i_rdata, i_ack,
      input  d_req, d_we, d_addr, d_wdata,
      output d_rdata, d_ack,
      input  g_req, g_we, g_addr, g_wdata,
      output g_rdata, g_ack,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output i_req, i_addr,
      input  i_rdata, i_ack,
      output d_req, d_we, d_addr, d_wdata,
      input  d_rdata, d_ack,
      output g_req, g_we, g_addr, g_wdata,
      input  g_rdata, g_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/jac1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// jac1_mem_arbiter
// Shares the single-port program/data RAM of the Jac1-8 core between
// instruction fetch (I), data load/store (D) and the debug loader (G).
// One access at a time through a four-state sequencer:
//   IDLE -> ISSUE (mem_en) -> WAIT (RAM read latency) -> DONE (ack) -> IDLE
// Debug has strict priority; I and D alternate when both request.
// Ports:
//   clk       : system clock, rising edge
//   sys_res_n : asynchronous active-low reset
//   bus       : jac1_mem_arbiter_if.slave (requester ports, RAM port, busy)
// All outputs come from registers or from the state register alone, so no
// request/address input reaches an output combinationally.
// ---------------------------------------------------------------------------
module jac1_mem_arbiter #(
   parameter int DataWidth = 8,
   parameter int AddrWidth = 8
) (
   input  logic                clk,
   input  logic                sys_res_n,
   jac1_mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ID_I = 2'd0,
      ID_D = 2'd1,
      ID_G = 2'd2
   } id_t;

   state_t               state, state_nxt;
   id_t                  win_id;
   id_t                  grant_id;
   logic                 grant_vld;

   // 1 = last I/D grant went to D. Reset to D so fetch wins the first tie.
   logic                 last_d;

   // Latched command; authoritative from IDLE until the next IDLE.
   logic                 cmd_we;
   logic [AddrWidth-1:0] cmd_addr;
   logic [DataWidth-1:0] cmd_wdata;

   logic [DataWidth-1:0] i_rdata_q, d_rdata_q, g_rdata_q;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // ---------------------------------------------------------------------
   // Winner selection and next state
   // ---------------------------------------------------------------------
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = ID_I;
      state_nxt = state;

      if (bus.g_req) begin
         grant_vld = 1'b1;
         grant_id  = ID_G;
      end else if (bus.i_req && bus.d_req) begin
         // Tie between I and D: the one not served last time wins.
         grant_vld = 1'b1;
         grant_id  = last_d ? ID_I : ID_D;
      end else if (bus.i_req) begin
         grant_vld = 1'b1;
         grant_id  = ID_I;
      end else if (bus.d_req) begin
         grant_vld = 1'b1;
         grant_id  = ID_D;
      end

      unique case (state)
         ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Command latch and round-robin history; only loaded on a grant in IDLE
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) begin
         win_id    <= ID_I;
         last_d    <= 1'b1;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (state == ST_IDLE && grant_vld) begin
         win_id <= grant_id;
         unique case (grant_id)
            ID_I: begin
               cmd_we    <= 1'b0;
               cmd_addr  <= bus.i_addr;
               cmd_wdata <= '0;
               last_d    <= 1'b0;
            end
            ID_D: begin
               cmd_we    <= bus.d_we;
               cmd_addr  <= bus.d_addr;
               cmd_wdata <= bus.d_wdata;
               last_d    <= 1'b1;
            end
            ID_G: begin
               // Debug grants leave the I/D history untouched.
               cmd_we    <= bus.g_we;
               cmd_addr  <= bus.g_addr;
               cmd_wdata <= bus.g_wdata;
            end
            default: begin
               cmd_we    <= 1'b0;
               cmd_addr  <= '0;
               cmd_wdata <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Read data capture: RAM data is valid in WAIT (one cycle after mem_en).
   // Each port's register holds until its next completed read.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge sys_res_n) begin
      if (!sys_res_n) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         g_rdata_q <= '0;
      end else if (state == ST_WAIT && !cmd_we) begin
         unique case (win_id)
            ID_I:    i_rdata_q <= bus.mem_rdata;
            ID_D:    d_rdata_q <= bus.mem_rdata;
            ID_G:    g_rdata_q <= bus.mem_rdata;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: state decode plus registered command/data
   // ---------------------------------------------------------------------
   assign bus.mem_en    = (state == ST_ISSUE);
   assign bus.mem_we    = (state == ST_ISSUE) && cmd_we;
   assign bus.mem_addr  = cmd_addr;
   assign bus.mem_wdata = cmd_wdata;

   assign bus.i_ack     = (state == ST_DONE) && (win_id == ID_I);
   assign bus.d_ack     = (state == ST_DONE) && (win_id == ID_D);
   assign bus.g_ack     = (state == ST_DONE) && (win_id == ID_G);

   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.g_rdata   = g_rdata_q;

   assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_jac1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jac1_mem_arbiter
// Directed sequence followed by a randomized phase. The reference model is
// transaction level: for each grant it picks the winner from the pending
// requests (debug first, then alternate I/D), and tracks RAM contents and
// the expected per-port read data in plain arrays.
// Port index used throughout: 0 = fetch, 1 = data, 2 = debug.
// ---------------------------------------------------------------------------
module tb_jac1_mem_arbiter;
   localparam int DW = 8;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jac1_mem_arbiter_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   jac1_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
      .clk       (clk),
      .sys_res_n (rst_n),
      .bus       (bus.slave)
   );

   // Synchronous-read single-port RAM
   logic [DW-1:0] ram [256];
   logic          ram_clr;
   always @(posedge clk) begin
      if (ram_clr) begin
         for (int a = 0; a < 256; a++) ram[a] <= 8'(a * 7 + 3);
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         bus.mem_rdata <= ram[bus.mem_addr];
      end
   end

   // Reference model state
   int            tests = 0;
   int            fails = 0;
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] exp_rd  [3];
   bit            last_d;
   bit            pend    [3];
   bit            c_we    [3];
   logic [AW-1:0] c_addr  [3];
   logic [DW-1:0] c_wd    [3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.i_req   = pend[0];
      bus.i_addr  = c_addr[0];
      bus.d_req   = pend[1];
      bus.d_we    = c_we[1];
      bus.d_addr  = c_addr[1];
      bus.d_wdata = c_wd[1];
      bus.g_req   = pend[2];
      bus.g_we    = c_we[2];
      bus.g_addr  = c_addr[2];
      bus.g_wdata = c_wd[2];
   endtask

   task automatic set_cmd(input int p, input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
      pend[p]   = 1'b1;
      c_addr[p] = a;
      c_we[p]   = (p == 0) ? 1'b0 : we;
      c_wd[p]   = (p == 0) ? '0 : wd;
   endtask

   // Run one arbitration from IDLE. Called at a negedge with the arbiter idle;
   // returns at the negedge of the following IDLE cycle.
   task automatic run_txn(input bit early);
      int            w;
      int            lat;
      int            en_cnt;
      int            stray;
      logic [AW-1:0] iss_a;
      logic [DW-1:0] iss_wd;
      logic          iss_we;
      logic [2:0]    ackv;

      if (pend[2])                w = 2;
      else if (pend[0] && pend[1]) w = last_d ? 0 : 1;
      else if (pend[0])           w = 0;
      else                        w = 1;
      if (w != 2) last_d = (w == 1);

      drive();
      lat = 0; en_cnt = 0; stray = 0; ackv = '0;
      iss_a = '0; iss_wd = '0; iss_we = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (early && c == 1) begin
            pend[w] = 1'b0;
            drive();
         end
         if (bus.mem_en) begin
            en_cnt++;
            iss_a  = bus.mem_addr;
            iss_we = bus.mem_we;
            iss_wd = bus.mem_wdata;
         end else if (bus.mem_we) begin
            stray++;
         end
         ackv = {bus.g_ack, bus.d_ack, bus.i_ack};
         if (ackv != 3'b000) begin
            lat = c;
            break;
         end
      end

      if (c_we[w]) ref_mem[c_addr[w]] = c_wd[w];
      else         exp_rd[w] = ref_mem[c_addr[w]];

      check("ack_port",  32'(ackv), 32'(3'b001 << w));
      check("ack_lat",   32'(lat), 32'd3);
      check("mem_en_cnt", 32'(en_cnt), 32'd1);
      check("stray_we",  32'(stray), 32'd0);
      check("iss_addr",  32'(iss_a), 32'(c_addr[w]));
      check("iss_we",    32'(iss_we), 32'(c_we[w]));
      if (c_we[w]) check("iss_wdata", 32'(iss_wd), 32'(c_wd[w]));
      check("i_rdata",   32'(bus.i_rdata), 32'(exp_rd[0]));
      check("d_rdata",   32'(bus.d_rdata), 32'(exp_rd[1]));
      check("g_rdata",   32'(bus.g_rdata), 32'(exp_rd[2]));

      pend[w] = 1'b0;
      drive();
      @(negedge clk);
      check("idle_after", 32'({bus.busy, bus.mem_en, bus.g_ack, bus.d_ack, bus.i_ack}), 32'd0);
   endtask

   initial begin
      int seen;
      for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a * 7 + 3);
      for (int p = 0; p < 3; p++) begin
         exp_rd[p] = '0; pend[p] = 1'b0; c_we[p] = 1'b0; c_addr[p] = '0; c_wd[p] = '0;
      end
      last_d  = 1'b1;
      ram_clr = 1'b1;
      drive();

      // Reset state
      repeat (2) @(negedge clk);
      ram_clr = 1'b0;
      check("rst_ctrl", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.g_ack, bus.d_ack, bus.i_ack}), 32'd0);
      check("rst_rdata", 32'({bus.i_rdata, bus.d_rdata, bus.g_rdata}), 32'd0);
      check("rst_addr", 32'({bus.mem_addr, bus.mem_wdata}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted mid-ISSUE: outputs drop immediately, no ack afterwards
      set_cmd(0, 8'h33, 1'b0, 8'h00);
      drive();
      @(negedge clk);
      check("pre_rst_issue", 32'({bus.busy, bus.mem_en}), 32'b11);
      #2 rst_n = 1'b0;
      #1 check("mid_rst_outs", 32'({bus.busy, bus.mem_en, bus.mem_we, bus.g_ack, bus.d_ack, bus.i_ack}), 32'd0);
      pend[0] = 1'b0;
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy || bus.i_ack || bus.d_ack || bus.g_ack) seen++;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);

      // Debug loader writes 0xA5 to 0x10, then a single fetch reads it
      set_cmd(2, 8'h10, 1'b1, 8'hA5);
      run_txn(1'b0);
      set_cmd(0, 8'h10, 1'b0, 8'h00);
      run_txn(1'b0);
      check("fetch_a5", 32'(bus.i_rdata), 32'h00A5);

      // Data write then read back
      set_cmd(1, 8'h20, 1'b1, 8'h3C);
      run_txn(1'b0);
      set_cmd(1, 8'h20, 1'b0, 8'h00);
      run_txn(1'b0);
      check("d_rd_3c", 32'(bus.d_rdata), 32'h003C);
      set_cmd(1, 8'h21, 1'b1, 8'h77);
      run_txn(1'b0);
      check("d_rd_hold", 32'(bus.d_rdata), 32'h003C);

      // Round-robin with I and D both requesting
      for (int k = 0; k < 6; k++) begin
         if (!pend[0]) set_cmd(0, 8'($urandom_range(0, 63)), 1'b0, 8'h00);
         if (!pend[1]) set_cmd(1, 8'($urandom_range(0, 63)), 1'b0, 8'h00);
         run_txn(1'b0);
      end

      // Debug priority over pending I/D, then I/D resume alternating
      for (int k = 0; k < 7; k++) begin
         if (k < 3 && !pend[2]) set_cmd(2, 8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 8'($urandom));
         if (!pend[0]) set_cmd(0, 8'($urandom_range(0, 63)), 1'b0, 8'h00);
         if (!pend[1]) set_cmd(1, 8'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 8'($urandom));
         run_txn(1'b0);
      end
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive();
      @(negedge clk);

      // Data request dropped one cycle after being sampled
      set_cmd(1, 8'h44, 1'b0, 8'h00);
      run_txn(1'b1);

      // Randomized mix over a small address window
      for (int k = 0; k < 40; k++) begin
         for (int p = 0; p < 3; p++) begin
            if (!pend[p] && $urandom_range(0, 3) < ((p == 2) ? 1 : 2))
               set_cmd(p, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 8'($urandom));
         end
         if (!pend[0] && !pend[1] && !pend[2]) set_cmd(0, 8'($urandom_range(0, 15)), 1'b0, 8'h00);
         run_txn(1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
